// File: rtl/instr_mem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam int         DEPTH_DEF    = 256;
  localparam logic [7:0] NOP_WORD_DEF = 8'h00;

endpackage

// File: rtl/instr_ram.sv
// DEPTH x 8 instruction RAM: one synchronous write port, one asynchronous read port.
module instr_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_loader.sv
// Clears the instruction RAM, loads a program over valid/ready, then releases the core and serves fetches.
// Optional trailing checksum byte verification is enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int         DEPTH    = DEPTH_DEF,
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadAddress,
  output logic [7:0]        instruction,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   load_count
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              accept, is_last;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [7:0]        ram_wdata, ram_rdata;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  always_comb begin
    accept    = load_valid && (state_q == ST_LOAD);
    // The top RAM slot always ends the program so wr_ptr never wraps.
    is_last   = load_last || (wr_ptr_q == LAST_IDX);
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = clr_ptr_q;
    ram_wdata = NOP_WORD;
`ifdef INSTR_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + PTR_ONE;
        if (clr_ptr_q == LAST_IDX) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_d = sum_q + load_data;
          // The final byte is the checksum itself and never lands in RAM.
          if (is_last) begin
            state_d = (sum_d == 8'h00) ? ST_RUN : ST_ERROR;
          end else begin
            ram_we    = 1'b1;
            ram_waddr = wr_ptr_q;
            ram_wdata = load_data;
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            cnt_d     = cnt_q + CNT_ONE;
          end
`else
          ram_we    = 1'b1;
          ram_waddr = wr_ptr_q;
          ram_wdata = load_data;
          cnt_d     = cnt_q + CNT_ONE;
          if (is_last) begin
            state_d = ST_RUN;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  instr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we && !reset),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ReadAddress[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign load_ready  = (state_q == ST_LOAD);
  assign load_done   = (state_q == ST_RUN);
  assign cpu_hold    = (state_q != ST_RUN);
  assign load_count  = cnt_q;
  assign instruction = (load_done && ({1'b0, ReadAddress} < DEPTH_W)) ? ram_rdata : NOP_WORD;

`ifdef INSTR_LOADER_CHECKSUM_EN
  assign load_error  = (state_q == ST_ERROR);
`else
  assign load_error  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader against a program-level reference model.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] ReadAddress;
  logic [7:0]        instruction;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   load_count;

  instr_mem_loader dut (
    .clk         (clk),
    .reset       (reset),
    .ReadAddress (ReadAddress),
    .instruction (instruction),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_error  (load_error),
    .load_count  (load_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        exp;
  } fetch_t;

  int         total = 0;
  int         bad   = 0;
  fetch_t     fetch_q [$];
  int         done_q [$];
  logic       rd_vld = 1'b0;
  logic       done_seen = 1'b0;
  logic [7:0] model_mem [DEPTH];
  bit         model_run = 1'b0;
  logic [7:0] prog [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each presented fetch and each completed load against queued expectations.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (fetch_q.size() == 0) begin
        check("fetch_queue_underflow", 1, 0);
      end else begin
        fetch_t f;
        f = fetch_q.pop_front();
        check($sformatf("instruction@%0d", f.addr), instruction, f.exp);
      end
    end
    if (reset) begin
      done_seen <= 1'b0;
    end else if (load_done && !done_seen) begin
      done_seen <= 1'b1;
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else                    check("done_load_count", load_count, done_q.pop_front());
      check("done_cpu_hold", cpu_hold, 0);
    end
  end

  task automatic do_reset();
    int  cyc;
    bit  hold_ok;
    rd_vld     = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_load_count", load_count, 0);
    @(posedge clk); #1;
    reset     = 1'b0;
    model_run = 1'b0;
    foreach (model_mem[i]) model_mem[i] = NOP_WORD_DEF;
    cyc     = 0;
    hold_ok = 1'b1;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (load_ready) break;
      if (!cpu_hold) hold_ok = 1'b0;
    end
    check("clear_cycles_to_ready", cyc, DEPTH + 1);
    check("hold_during_clear", hold_ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic build_prog(input int len);
    logic [7:0] s;
    prog.delete();
    for (int i = 0; i < len; i++) prog.push_back(8'($urandom_range(0, 255)));
`ifdef INSTR_LOADER_CHECKSUM_EN
    s = 8'h00;
    for (int i = 0; i < len - 1; i++) s = s + prog[i];
    prog[len-1] = 8'h00 - s;
`else
    s = 8'h00;
`endif
  endtask

  // vmode: 0 = valid every cycle, 1 = alternating, 2 = random. stop_at < size sends a partial program.
  task automatic load_prog(input bit use_last, input int vmode, input int stop_at);
    int         n, idx, cyc, stored;
    bit         ok, acc, tog, seen;
    logic [7:0] sum;
    n   = prog.size();
    sum = 8'h00;
    foreach (prog[i]) sum = sum + prog[i];
`ifdef INSTR_LOADER_CHECKSUM_EN
    stored = n - 1;
    ok     = (sum == 8'h00);
`else
    stored = n;
    ok     = 1'b1;
`endif
    if (stop_at == n && ok) done_q.push_back(stored);
    idx = 0;
    cyc = 0;
    tog = 1'b1;
    while (idx < stop_at && cyc < 2000) begin
      load_data = prog[idx];
      load_last = use_last && (idx == n - 1);
      case (vmode)
        0:       load_valid = 1'b1;
        1:       begin load_valid = tog; tog = !tog; end
        default: load_valid = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      acc = load_valid && load_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("bytes_accepted", idx, stop_at);
    if (stop_at == n) begin
      for (int i = 0; i < stored; i++) model_mem[i] = prog[i];
      model_run = ok;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (load_done || load_error) begin seen = 1'b1; break; end
      end
      check("outcome_seen", seen, 1);
      check("post_load_ready", load_ready, 0);
      check("post_load_done", load_done, ok);
      check("post_load_error", load_error, !ok);
      check("post_cpu_hold", cpu_hold, !ok);
      check("post_load_count", load_count, stored);
      @(posedge clk); #1;
    end
  endtask

  task automatic fetch(input int a);
    fetch_t f;
    f.addr      = a[ADDR_W-1:0];
    f.exp       = model_run ? model_mem[a] : NOP_WORD_DEF;
    ReadAddress = a[ADDR_W-1:0];
    fetch_q.push_back(f);
    rd_vld      = 1'b1;
    @(posedge clk); #1;
    rd_vld      = 1'b0;
  endtask

  task automatic poke_while_running(input int cycles, input int exp_cnt);
    for (int i = 0; i < cycles; i++) begin
      load_valid = 1'b1;
      load_last  = 1'($urandom_range(0, 1));
      load_data  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clk);
    check("count_frozen_in_run", load_count, exp_cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit err_ok;
    reset       = 1'b1;
    load_valid  = 1'b0;
    load_data   = 8'h00;
    load_last   = 1'b0;
    ReadAddress = '0;

    do_reset();
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_load_ready", load_ready, 1);
    check("idle_cpu_hold", cpu_hold, 1);
    check("idle_load_done", load_done, 0);
    @(posedge clk); #1;
    for (int a = 0; a < DEPTH; a++) fetch(a);

    prog = '{8'h41, 8'h52, 8'hC3};
    load_prog(1'b1, 0, 3);
    for (int a = 0; a < 4; a++) fetch(a);

    do_reset();
    build_prog(5);
    load_prog(1'b1, 1, 5);
    for (int a = 0; a < 7; a++) fetch(a);

    do_reset();
    build_prog(4);
    load_prog(1'b0, 0, 2);
    do_reset();
    prog = '{8'h7F};
    load_prog(1'b1, 0, 1);
    fetch(0);
    fetch(1);
    fetch(2);

    do_reset();
    build_prog(DEPTH);
    load_prog(1'b0, 2, DEPTH);
    poke_while_running(6, model_run ? DEPTH - ((prog.size() == DEPTH) ? 0 : 0) -
`ifdef INSTR_LOADER_CHECKSUM_EN
                       1
`else
                       0
`endif
                       : 0);
    fetch(0);
    fetch(1);
    fetch(DEPTH - 2);
    fetch(DEPTH - 1);
    repeat (8) fetch(int'($urandom_range(0, DEPTH - 1)));

`ifdef INSTR_LOADER_CHECKSUM_EN
    do_reset();
    prog = '{8'h10, 8'h20, 8'hD0};
    load_prog(1'b1, 0, 3);
    for (int a = 0; a < 3; a++) fetch(a);

    do_reset();
    prog = '{8'h10, 8'h20, 8'hD1};
    load_prog(1'b1, 0, 3);
    err_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!(load_error && cpu_hold && !load_ready && !load_done)) err_ok = 1'b0;
    end
    check("error_held_50", err_ok, 1);
    @(posedge clk); #1;
    fetch(0);
    do_reset();
`else
    err_ok = 1'b1;
`endif

    repeat (4) begin
      do_reset();
      n = int'($urandom_range(1, 24));
      build_prog(n);
      load_prog(1'b1, int'($urandom_range(0, 2)), n);
      for (int a = 0; a < n + 2; a++) fetch(a);
      repeat (4) fetch(int'($urandom_range(0, DEPTH - 1)));
    end

    repeat (2) @(posedge clk);
    check("fetch_queue_drained", fetch_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
